stopwatch_controller: RTL and testbench
=======================================

Name: stopwatch_controller

Overview:
Sequences the stopwatch datapath. Interprets start/stop, lap and clear button pulses, and gates and re-phases the 1 s tick divider through its enable and reset. Counts elapsed time as MM:SS BCD and provides a live or lap-frozen value to the 7-segment display driver. Sits between the debounced button logic and the divider/display blocks.

Parameters:
TICK_PRESCALE, 1, number of divider tick pulses per one-second increment (legal 1..255)
MIN_TENS_MAX, 5, maximum value of the minutes-tens digit (5 gives 59:59 full scale)

Ports:
clk  input  1  board clock
rst  input  1  asynchronous, active-high reset
btn_start_stop  input  1  single-cycle pulse: toggle run/pause
btn_lap  input  1  single-cycle pulse: freeze/release display while running
btn_clear  input  1  single-cycle pulse: return to zero
tick  input  1  divider threshold pulse, one clk wide
divider_enable  output  1  enable to the tick divider
divider_rst  output  1  one-cycle synchronous re-phase pulse to the divider
display_bcd  output  16  {min_tens, min_ones, sec_tens, sec_ones}, live or frozen
running  output  1  high in RUNNING or LAP
lap_active  output  1  high in LAP
overflow  output  1  one-cycle pulse on 59:59 -> 00:00 wrap

Behaviour:
- Reset (async): state IDLE, count 00:00, lap snapshot 0, prescale counter 0. All outputs 0.
- States:
  - IDLE: count is zero.
    - start_stop -> RUNNING, with divider_rst pulsed in the transition cycle.
  - RUNNING:
    - start_stop -> PAUSED.
    - lap -> LAP; the snapshot loads the current count.
  - LAP: counting continues, display shows the snapshot.
    - lap -> RUNNING (display goes live).
    - start_stop -> PAUSED (display goes live).
  - PAUSED:
    - start_stop -> RUNNING, with no divider_rst, so the sub-second phase is kept.
    - lap is ignored.
- clear, from any state: -> IDLE next cycle. Count, snapshot and prescale are zeroed, and divider_rst pulses one cycle.
- Priority in the same cycle: clear > start_stop > lap.
- divider_enable = 1 in RUNNING and LAP only; registered, updating the cycle after the state changes.
- Tick counting:
  - A tick is accepted when the current state is RUNNING or LAP.
  - A tick coincident with the start_stop that pauses is still counted.
  - A tick coincident with clear is discarded.
- Prescale counter: 8-bit. On an accepted tick it increments; when it reaches TICK_PRESCALE-1 it clears and the count increments by one second.
- BCD increment:
  - sec_ones 0..9, carry to sec_tens 0..5.
  - sec_tens carries to min_ones 0..9.
  - min_ones carries to min_tens 0..MIN_TENS_MAX.
  - Full scale wraps to 00:00 and pulses overflow in that cycle.
- Latency:
  - display_bcd reflects an increment one clk after the accepting tick.
  - The lap snapshot captures the count registered in the lap cycle, i.e. excluding a same-cycle increment.
- display_bcd = snapshot in LAP, live count otherwise. It is registered.

Optional Feature:
STOPWATCH_SATURATE_EN.
- Defined: at full scale the count holds, the state forces to PAUSED, overflow pulses once, and further ticks are ignored until clear.
- Undefined: wrap-around as in Behaviour.

Decomposition:
- Package stopwatch_pkg holds:
  - the state encoding (IDLE, RUNNING, LAP, PAUSED; 2 bits)
  - the BCD digit width of 4
  - digit maxima 9 and 5
  - the display_bcd field offsets
- One sub-module, bcd_digit_counter: parameter MAX; inputs clk, rst, clr, inc; outputs digit[3:0] and carry (combinational, inc && digit==MAX). Instantiated four times in a carry chain.

Test Plan:
- Reset, then start_stop; send 3 ticks (TICK_PRESCALE=1) -> display_bcd 0x0003, running=1, divider_rst high exactly in the start cycle.
- Run to 00:59, then 1 tick -> 0x0100. Preload to 59:59, then 1 tick -> 0x0000 with overflow pulsed one cycle. With STOPWATCH_SATURATE_EN: display holds 0x5959, state PAUSED.
- At 00:10 send lap, then 5 ticks -> display 0x0010, lap_active=1. Then lap -> display 0x0015.
- start_stop and tick in the same cycle while RUNNING -> the tick counts, state PAUSED, divider_enable=0 next cycle. Further ticks are ignored. start_stop again -> resumes with no divider_rst.
- clear, start_stop and tick in the same cycle at 02:30 -> IDLE, 0x0000, divider_rst pulsed, running=0.
- TICK_PRESCALE=4: send 7 ticks -> 0x0001. Pause, resume, 1 tick -> 0x0002, confirming prescale phase is kept across pause.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// -----------------------------------------------------------------------------
// stopwatch_pkg
// Shared definitions for the stopwatch controller:
//   - state_t        : controller FSM encoding (IDLE, RUNNING, LAP, PAUSED)
//   - DIGIT_W        : width of one BCD digit
//   - DIGIT_MAX_*    : digit maxima for ones (9) and seconds-tens (5) digits
//   - *_LSB          : bit offsets of each digit inside display_bcd
//   - digit_max()    : maximum value of digit position idx (0 = sec_ones)
//   - bcd_next()     : next value of one BCD digit given clear / increment
//   - is_counting()  : true in the states where ticks are accepted
// -----------------------------------------------------------------------------
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_LAP     = 2'd2,
        ST_PAUSED  = 2'd3
    } state_t;

    localparam int DIGIT_W        = 4;
    localparam int DIGIT_MAX_NINE = 9;
    localparam int DIGIT_MAX_FIVE = 5;
    localparam int NUM_DIGITS     = 4;
    localparam int DISPLAY_W      = NUM_DIGITS * DIGIT_W;

    localparam int SEC_ONES_LSB = 0;
    localparam int SEC_TENS_LSB = 4;
    localparam int MIN_ONES_LSB = 8;
    localparam int MIN_TENS_LSB = 12;

    // Digit positions, least significant first: sec_ones, sec_tens,
    // min_ones, min_tens. The top digit's limit is configurable.
    function automatic int digit_max(input int idx, input int min_tens_max);
        case (idx)
            0:       return DIGIT_MAX_NINE;
            1:       return DIGIT_MAX_FIVE;
            2:       return DIGIT_MAX_NINE;
            default: return min_tens_max;
        endcase
    endfunction

    function automatic logic [DIGIT_W-1:0] bcd_next(
        input logic [DIGIT_W-1:0] d,
        input logic [DIGIT_W-1:0] max,
        input logic               inc,
        input logic               clr
    );
        if (clr) begin
            return '0;
        end
        if (!inc) begin
            return d;
        end
        return (d == max) ? '0 : d + 1'b1;
    endfunction

    function automatic logic is_counting(input state_t s);
        return (s == ST_RUNNING) || (s == ST_LAP);
    endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// -----------------------------------------------------------------------------
// bcd_digit_counter
// One BCD digit that counts 0..MAX and wraps, with a combinational carry so
// several instances form a ripple carry chain.
// Ports:
//   clk   : clock
//   rst   : asynchronous active-high reset (digit -> 0)
//   clr   : synchronous clear (digit -> 0), wins over inc
//   inc   : increment request
//   digit : current digit value
//   carry : inc && digit == MAX (the digit wraps on this edge)
// -----------------------------------------------------------------------------
module bcd_digit_counter
    import stopwatch_pkg::*;
#(
    parameter int MAX = 9
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               inc,
    output logic [DIGIT_W-1:0] digit,
    output logic               carry
);

    localparam logic [DIGIT_W-1:0] MAX_L = DIGIT_W'(MAX);

    logic [DIGIT_W-1:0] digit_q;
    logic [DIGIT_W-1:0] digit_d;

    always_comb begin
        digit_d = bcd_next(digit_q, MAX_L, inc, clr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit = digit_q;
    assign carry = inc && (digit_q == MAX_L);

endmodule

// File: rtl/stopwatch_controller.sv
// -----------------------------------------------------------------------------
// stopwatch_controller
// Sequences the stopwatch: decodes start/stop, lap and clear pulses, gates and
// re-phases the 1 s tick divider, counts elapsed MM:SS in BCD and presents
// either the live count or a frozen lap snapshot to the display driver.
//
// Build option: define STOPWATCH_SATURATE_EN to hold at full scale (state
// forced to PAUSED, overflow pulses once, ticks ignored until clear) instead
// of wrapping to 00:00.
//
// Ports:
//   clk            : board clock
//   rst            : asynchronous active-high reset
//   btn_start_stop : pulse, toggle run/pause (start from IDLE)
//   btn_lap        : pulse, freeze/release display while running
//   btn_clear      : pulse, return to zero from any state
//   tick           : divider threshold pulse, one clk wide
//   divider_enable : divider enable, high one cycle after entering RUNNING/LAP
//   divider_rst    : one-cycle divider re-phase pulse (start from IDLE, clear)
//   display_bcd    : {min_tens, min_ones, sec_tens, sec_ones}
//   running        : high in RUNNING or LAP
//   lap_active     : high in LAP
//   overflow       : one-cycle pulse on reaching past full scale
// -----------------------------------------------------------------------------
module stopwatch_controller
    import stopwatch_pkg::*;
#(
    parameter int TICK_PRESCALE = 1,
    parameter int MIN_TENS_MAX  = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 btn_start_stop,
    input  logic                 btn_lap,
    input  logic                 btn_clear,
    input  logic                 tick,
    output logic                 divider_enable,
    output logic                 divider_rst,
    output logic [DISPLAY_W-1:0] display_bcd,
    output logic                 running,
    output logic                 lap_active,
    output logic                 overflow
);

    localparam logic [7:0] PRESC_LAST = 8'(TICK_PRESCALE - 1);

    // Registers
    state_t               state_q,   state_d;
    logic [7:0]           presc_q,   presc_d;
    logic [DISPLAY_W-1:0] snap_q,    snap_d;
    logic [DISPLAY_W-1:0] display_q, display_d;
    logic                 divider_enable_q, divider_enable_d;
    logic                 divider_rst_q,    divider_rst_d;
    logic                 running_q,        running_d;
    logic                 lap_active_q,     lap_active_d;
    logic                 overflow_q,       overflow_d;

    // Datapath
    logic                 tick_ok;
    logic                 step;
    logic                 count_inc;
    logic [NUM_DIGITS-1:0] digit_inc;
    logic [NUM_DIGITS-1:0] carry;
    logic [DIGIT_W-1:0]   digit [NUM_DIGITS];
    logic [DISPLAY_W-1:0] count_q;
    logic [DISPLAY_W-1:0] count_next;

`ifdef STOPWATCH_SATURATE_EN
    localparam logic [DISPLAY_W-1:0] FULL_SCALE = {DIGIT_W'(MIN_TENS_MAX),
                                                   DIGIT_W'(DIGIT_MAX_NINE),
                                                   DIGIT_W'(DIGIT_MAX_FIVE),
                                                   DIGIT_W'(DIGIT_MAX_NINE)};
    logic sat_q, sat_d;
    logic sat_hit;
`endif

    // BCD carry chain. count_next mirrors what the digit registers will hold
    // after this edge so display_bcd can be registered without an extra cycle
    // of latency.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            localparam int MAX_G = digit_max(gi, MIN_TENS_MAX);

            if (gi == 0) begin : g_first
                assign digit_inc[gi] = count_inc;
            end else begin : g_chain
                assign digit_inc[gi] = carry[gi-1];
            end

            bcd_digit_counter #(
                .MAX (MAX_G)
            ) u_digit (
                .clk   (clk),
                .rst   (rst),
                .clr   (btn_clear),
                .inc   (digit_inc[gi]),
                .digit (digit[gi]),
                .carry (carry[gi])
            );

            assign count_q[gi*DIGIT_W +: DIGIT_W]    = digit[gi];
            assign count_next[gi*DIGIT_W +: DIGIT_W] =
                bcd_next(digit[gi], DIGIT_W'(MAX_G), digit_inc[gi], btn_clear);
        end
    endgenerate

    // Tick acceptance and prescaling. Acceptance looks at the registered
    // state, so a tick arriving with the pausing start_stop still counts.
    always_comb begin
        tick_ok = tick && !btn_clear && is_counting(state_q);
`ifdef STOPWATCH_SATURATE_EN
        tick_ok = tick_ok && !sat_q;
`endif
        step    = tick_ok && (presc_q == PRESC_LAST);

        presc_d = presc_q;
        if (btn_clear) begin
            presc_d = '0;
        end else if (tick_ok) begin
            presc_d = step ? 8'd0 : presc_q + 8'd1;
        end

`ifdef STOPWATCH_SATURATE_EN
        sat_hit   = step && (count_q == FULL_SCALE);
        count_inc = step && !sat_hit;
`else
        count_inc = step;
`endif
    end

    // Controller FSM next state and registered output values.
    always_comb begin
        state_d       = state_q;
        snap_d        = snap_q;
        divider_rst_d = 1'b0;

        if (btn_clear) begin
            state_d       = ST_IDLE;
            snap_d        = '0;
            divider_rst_d = 1'b1;
        end else begin
            if (btn_start_stop) begin
                case (state_q)
                    ST_IDLE: begin
                        state_d       = ST_RUNNING;
                        divider_rst_d = 1'b1;
                    end
                    ST_RUNNING: state_d = ST_PAUSED;
                    ST_LAP:     state_d = ST_PAUSED;
                    // Resume keeps the divider phase: no re-phase pulse.
                    default:    state_d = ST_RUNNING;
                endcase
            end else if (btn_lap) begin
                if (state_q == ST_RUNNING) begin
                    state_d = ST_LAP;
                    // Registered count, not count_next: a same-cycle
                    // increment is excluded from the snapshot.
                    snap_d  = count_q;
                end else if (state_q == ST_LAP) begin
                    state_d = ST_RUNNING;
                end
            end
`ifdef STOPWATCH_SATURATE_EN
            if (sat_hit) begin
                state_d = ST_PAUSED;
            end
`endif
        end

`ifdef STOPWATCH_SATURATE_EN
        sat_d      = btn_clear ? 1'b0 : (sat_q || sat_hit);
        // carry[3] never fires here because the chain input is gated at
        // full scale; it is folded in only so the chain end is consumed.
        overflow_d = sat_hit || carry[NUM_DIGITS-1];
`else
        // Carry out of the top digit means every digit wrapped: 59:59 -> 00:00.
        overflow_d = carry[NUM_DIGITS-1];
`endif

        display_d        = (state_d == ST_LAP) ? snap_d : count_next;
        running_d        = is_counting(state_d);
        lap_active_d     = (state_d == ST_LAP);
        // Follows the registered state, so the enable trails the state
        // change by one cycle and the re-phase pulse lands while disabled.
        divider_enable_d = is_counting(state_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            presc_q          <= '0;
            snap_q           <= '0;
            display_q        <= '0;
            divider_enable_q <= 1'b0;
            divider_rst_q    <= 1'b0;
            running_q        <= 1'b0;
            lap_active_q     <= 1'b0;
            overflow_q       <= 1'b0;
`ifdef STOPWATCH_SATURATE_EN
            sat_q            <= 1'b0;
`endif
        end else begin
            state_q          <= state_d;
            presc_q          <= presc_d;
            snap_q           <= snap_d;
            display_q        <= display_d;
            divider_enable_q <= divider_enable_d;
            divider_rst_q    <= divider_rst_d;
            running_q        <= running_d;
            lap_active_q     <= lap_active_d;
            overflow_q       <= overflow_d;
`ifdef STOPWATCH_SATURATE_EN
            sat_q            <= sat_d;
`endif
        end
    end

    assign divider_enable = divider_enable_q;
    assign divider_rst    = divider_rst_q;
    assign display_bcd    = display_q;
    assign running        = running_q;
    assign lap_active     = lap_active_q;
    assign overflow       = overflow_q;

endmodule

// File: tb/tb_stopwatch_controller.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_controller
// Two controller instances share one clock: unit 0 with TICK_PRESCALE=1 and
// unit 1 with TICK_PRESCALE=4. Every cycle a behavioural model (elapsed time
// kept as plain seconds) predicts all outputs of both units; the predictions
// are queued when the inputs are driven and compared after the clock edge.
// Directed checks against literal values mark the key scenarios.
// Honours STOPWATCH_SATURATE_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_stopwatch_controller;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_LAP   = 2;
    localparam int M_PAUSE = 3;
    localparam int FULL_SECS = 5 * 600 + 9 * 60 + 59;   // 59:59

    typedef struct packed {
        logic [15:0] disp;
        logic        run;
        logic        lap;
        logic        en;
        logic        drst;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  ss, lp, clr, tk;
    logic [1:0]  en, drst, run, lapa, ovf;
    logic [15:0] disp0, disp1;

    int n_cmp = 0;
    int n_bad = 0;

    exp_t sb_q[$];

    int m_state [2];
    int m_secs  [2];
    int m_snap  [2];
    int m_presc [2];
    bit m_sat   [2];
    int m_div   [2] = '{1, 4};

    always #5 clk = ~clk;

    stopwatch_controller #(.TICK_PRESCALE(1)) dut0 (
        .clk            (clk),
        .rst            (rst),
        .btn_start_stop (ss[0]),
        .btn_lap        (lp[0]),
        .btn_clear      (clr[0]),
        .tick           (tk[0]),
        .divider_enable (en[0]),
        .divider_rst    (drst[0]),
        .display_bcd    (disp0),
        .running        (run[0]),
        .lap_active     (lapa[0]),
        .overflow       (ovf[0])
    );

    stopwatch_controller #(.TICK_PRESCALE(4)) dut1 (
        .clk            (clk),
        .rst            (rst),
        .btn_start_stop (ss[1]),
        .btn_lap        (lp[1]),
        .btn_clear      (clr[1]),
        .tick           (tk[1]),
        .divider_enable (en[1]),
        .divider_rst    (drst[1]),
        .display_bcd    (disp1),
        .running        (run[1]),
        .lap_active     (lapa[1]),
        .overflow       (ovf[1])
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int secs);
        int mm;
        int sc;
        logic [15:0] r;
        mm = secs / 60;
        sc = secs % 60;
        r  = {4'(mm / 10), 4'(mm % 10), 4'(sc / 10), 4'(sc % 10)};
        return r;
    endfunction

    // Behavioural reference for one unit over one clock edge.
    task automatic model_step(input int u, input bit s, input bit l, input bit c,
                              input bit t, output exp_t e);
        bit was_run;
        int old_secs;
        bit hit;
        was_run  = (m_state[u] == M_RUN) || (m_state[u] == M_LAP);
        old_secs = m_secs[u];
        hit      = 1'b0;
        e.en     = was_run;
        e.drst   = c || (s && m_state[u] == M_IDLE);
        e.ovf    = 1'b0;
        if (c) begin
            m_state[u] = M_IDLE;
            m_secs[u]  = 0;
            m_snap[u]  = 0;
            m_presc[u] = 0;
            m_sat[u]   = 1'b0;
        end else begin
            if (t && was_run && !m_sat[u]) begin
                m_presc[u]++;
                if (m_presc[u] == m_div[u]) begin
                    m_presc[u] = 0;
                    if (m_secs[u] == FULL_SECS) begin
                        e.ovf = 1'b1;
`ifdef STOPWATCH_SATURATE_EN
                        hit      = 1'b1;
                        m_sat[u] = 1'b1;
`else
                        m_secs[u] = 0;
`endif
                    end else begin
                        m_secs[u]++;
                    end
                end
            end
            if (s) begin
                if (m_state[u] == M_IDLE || m_state[u] == M_PAUSE) m_state[u] = M_RUN;
                else m_state[u] = M_PAUSE;
            end else if (l) begin
                if (m_state[u] == M_RUN) begin
                    m_state[u] = M_LAP;
                    m_snap[u]  = old_secs;
                end else if (m_state[u] == M_LAP) begin
                    m_state[u] = M_RUN;
                end
            end
            if (hit) m_state[u] = M_PAUSE;
        end
        e.disp = (m_state[u] == M_LAP) ? to_bcd(m_snap[u]) : to_bcd(m_secs[u]);
        e.run  = (m_state[u] == M_RUN) || (m_state[u] == M_LAP);
        e.lap  = (m_state[u] == M_LAP);
    endtask

    task automatic compare_unit(input int u, input exp_t x);
        logic [15:0] d;
        d = (u == 0) ? disp0 : disp1;
        check_eq($sformatf("u%0d display_bcd", u), {16'd0, d},       {16'd0, x.disp});
        check_eq($sformatf("u%0d running", u),     {31'd0, run[u]},  {31'd0, x.run});
        check_eq($sformatf("u%0d lap_active", u),  {31'd0, lapa[u]}, {31'd0, x.lap});
        check_eq($sformatf("u%0d divider_enable", u), {31'd0, en[u]}, {31'd0, x.en});
        check_eq($sformatf("u%0d divider_rst", u), {31'd0, drst[u]}, {31'd0, x.drst});
        check_eq($sformatf("u%0d overflow", u),    {31'd0, ovf[u]},  {31'd0, x.ovf});
    endtask

    // One clock cycle: drive unit u, predict both units, compare after the edge.
    task automatic cyc(input int u, input bit s, input bit l, input bit c, input bit t);
        exp_t e;
        exp_t x;
        ss = '0; lp = '0; clr = '0; tk = '0;
        ss[u] = s; lp[u] = l; clr[u] = c; tk[u] = t;
        for (int k = 0; k < 2; k++) begin
            model_step(k, ss[k], lp[k], clr[k], tk[k], e);
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            x = sb_q.pop_front();
            compare_unit(k, x);
        end
        if (s || l || c)
            $display("txn u%0d ss=%0b lap=%0b clr=%0b tick=%0b -> disp0=%h disp1=%h",
                     u, s, l, c, t, disp0, disp1);
        ss = '0; lp = '0; clr = '0; tk = '0;
    endtask

    task automatic ticks(input int u, input int n);
        for (int i = 0; i < n; i++) begin
            cyc(u, 1'b0, 1'b0, 1'b0, 1'b1);
            if ($urandom_range(0, 3) == 0) cyc(u, 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        rst = 1'b1;
        ss = '0; lp = '0; clr = '0; tk = '0;
        for (int k = 0; k < 2; k++) begin
            m_state[k] = M_IDLE; m_secs[k] = 0; m_snap[k] = 0;
            m_presc[k] = 0; m_sat[k] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset display u0", {16'd0, disp0}, 32'd0);
        check_eq("reset display u1", {16'd0, disp1}, 32'd0);
        check_eq("reset flags", {27'd0, en[0], drst[0], run[0], lapa[0], ovf[0]}, 32'd0);
        check_eq("reset flags u1", {27'd0, en[1], drst[1], run[1], lapa[1], ovf[1]}, 32'd0);
        rst = 1'b0;
        cyc(0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Start, three ticks.
        cyc(0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("start divider_rst", {31'd0, drst[0]}, 32'd1);
        check_eq("start enable lag", {31'd0, en[0]}, 32'd0);
        ticks(0, 3);
        check_eq("3 ticks display", {16'd0, disp0}, 32'h0003);
        check_eq("3 ticks running", {31'd0, run[0]}, 32'd1);
        check_eq("3 ticks no re-phase", {31'd0, drst[0]}, 32'd0);

        // Seconds-to-minutes carry.
        ticks(0, 56);
        check_eq("00:59", {16'd0, disp0}, 32'h0059);
        ticks(0, 1);
        check_eq("01:00", {16'd0, disp0}, 32'h0100);

        // Lap freeze and release.
        cyc(0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(0, 1'b1, 1'b0, 1'b0, 1'b0);
        ticks(0, 10);
        cyc(0, 1'b0, 1'b1, 1'b0, 1'b1);   // lap with a tick: snapshot excludes it
        ticks(0, 4);
        check_eq("lap frozen", {16'd0, disp0}, 32'h0010);
        check_eq("lap_active", {31'd0, lapa[0]}, 32'd1);
        cyc(0, 1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("lap released", {16'd0, disp0}, 32'h0015);

        // Pause with a coincident tick.
        cyc(0, 1'b1, 1'b0, 1'b0, 1'b1);
        check_eq("pause tick counted", {16'd0, disp0}, 32'h0016);
        check_eq("paused running", {31'd0, run[0]}, 32'd0);
        cyc(0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("paused enable", {31'd0, en[0]}, 32'd0);
        ticks(0, 3);
        check_eq("paused ticks ignored", {16'd0, disp0}, 32'h0016);
        cyc(0, 1'b0, 1'b1, 1'b0, 1'b0);   // lap ignored in PAUSED
        check_eq("paused lap ignored", {31'd0, lapa[0]}, 32'd0);
        cyc(0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("resume no re-phase", {31'd0, drst[0]}, 32'd0);
        ticks(0, 1);
        check_eq("resumed counting", {16'd0, disp0}, 32'h0017);

        // Clear beats start_stop and tick at 02:30.
        cyc(0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(0, 1'b1, 1'b0, 1'b0, 1'b0);
        ticks(0, 150);
        check_eq("02:30", {16'd0, disp0}, 32'h0230);
        cyc(0, 1'b1, 1'b0, 1'b1, 1'b1);
        check_eq("clear display", {16'd0, disp0}, 32'h0000);
        check_eq("clear running", {31'd0, run[0]}, 32'd0);
        check_eq("clear divider_rst", {31'd0, drst[0]}, 32'd1);

        // Full scale.
        cyc(0, 1'b1, 1'b0, 1'b0, 1'b0);
        ticks(0, FULL_SECS);
        check_eq("59:59", {16'd0, disp0}, 32'h5959);
        cyc(0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("full-scale overflow", {31'd0, ovf[0]}, 32'd1);
`ifdef STOPWATCH_SATURATE_EN
        check_eq("saturate hold", {16'd0, disp0}, 32'h5959);
        check_eq("saturate paused", {31'd0, run[0]}, 32'd0);
        ticks(0, 2);
        cyc(0, 1'b1, 1'b0, 1'b0, 1'b0);
        ticks(0, 2);
        check_eq("saturate still held", {16'd0, disp0}, 32'h5959);
`else
        check_eq("wrap display", {16'd0, disp0}, 32'h0000);
        check_eq("wrap running", {31'd0, run[0]}, 32'd1);
`endif
        cyc(0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("overflow one cycle", {31'd0, ovf[0]}, 32'd0);
        cyc(0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Prescale 4 keeps its phase across pause/resume.
        cyc(1, 1'b1, 1'b0, 1'b0, 1'b0);
        ticks(1, 7);
        check_eq("u1 7 ticks", {16'd0, disp1}, 32'h0001);
        cyc(1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("u1 resume no re-phase", {31'd0, drst[1]}, 32'd0);
        cyc(1, 1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("u1 phase kept", {16'd0, disp1}, 32'h0002);
        cyc(1, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
